// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
// Settings travel as a fixed-width record; channels use the low CNT_W bits.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    // Widest counter supported; the settings record is sized to this.
    localparam int unsigned CFG_W     = 32;

    localparam logic [CFG_W-1:0] DEFAULT_DIV  = 32'd50_000_000;
    localparam logic [CFG_W-1:0] DEFAULT_HIGH = 32'd25_000_000;
    localparam int unsigned      MIN_DIV      = 2;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } clkdiv_cfg_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and pending settings, and registered
// clock/tick outputs. Pending settings land only on a period boundary.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV),
    parameter logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_HIGH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        stage_i,
    input  clkdiv_cfg_t cfg_i,
    output logic        busy_o,
    output logic        clk_o,
    output logic        tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    clkdiv_cfg_t      pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             at_end;
    logic             wrap;
    logic             apply;

    always_comb begin
        at_end = (cnt_q == div_q - CNT_W'(1));
        wrap   = en_i && at_end;
        // A disabled channel has no phase to protect, so it takes settings at once.
        apply  = busy_q && (!en_i || wrap);

        cnt_d  = (en_i && !at_end) ? cnt_q + CNT_W'(1) : '0;
        clk_d  = en_i && (cnt_q < high_q);
        tick_d = wrap;

        div_d  = div_q;
        high_d = high_q;
        pend_d = pend_q;
        busy_d = busy_q;

        if (apply) begin
            div_d  = pend_q.div[CNT_W-1:0];
            high_d = pend_q.high[CNT_W-1:0];
            busy_d = 1'b0;
        end
        // A fresh request always re-arms pending, even on the applying cycle.
        if (stage_i) begin
            pend_d = cfg_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            high_q <= RST_HIGH;
            pend_q <= '0;
            busy_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            high_q <= high_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign busy_o = busy_q;
    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider: validates load requests
// and fans the accepted settings out to NUM_CH independent channels.
module clock_divider_prog #(
    parameter int unsigned        NUM_CH       = 2,
    parameter int unsigned        CNT_W        = clkdiv_pkg::CNT_W_DEF,
    parameter logic [CNT_W-1:0]   DEFAULT_DIV  = CNT_W'(clkdiv_pkg::DEFAULT_DIV),
    parameter logic [CNT_W-1:0]   DEFAULT_HIGH = CNT_W'(clkdiv_pkg::DEFAULT_HIGH),
    localparam int unsigned       CH_W         = clkdiv_pkg::ch_w(NUM_CH)
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              load,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [CNT_W-1:0]  div_in,
    input  logic [CNT_W-1:0]  high_in,
    output logic              load_ok,
    output logic              load_err,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick
);

    import clkdiv_pkg::*;

    logic [31:0]       ch_ext;
    logic              div_ok;
    logic              ch_ok;
    logic              valid;
    logic [CNT_W-1:0]  high_clamp;
    clkdiv_cfg_t       cfg;
    logic [NUM_CH-1:0] stage;
    logic              ok_q, ok_d;
    logic              err_q, err_d;

    always_comb begin
        ch_ext     = 32'(ch_sel);
        div_ok     = (div_in >= CNT_W'(MIN_DIV));
        ch_ok      = (ch_ext < NUM_CH);
        valid      = load && div_ok && ch_ok;
        // A high time at or beyond the period would never go low; hold one low cycle.
        high_clamp = (high_in >= div_in) ? div_in - CNT_W'(1) : high_in;
        cfg.div    = CFG_W'(div_in);
        cfg.high   = CFG_W'(high_clamp);
        ok_d       = valid;
        err_d      = load && !valid;
        stage      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            stage[i] = valid && (ch_ext == i);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ok_q  <= ok_d;
            err_q <= err_d;
        end
    end

    assign load_ok  = ok_q;
    assign load_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        clkdiv_channel #(
            .CNT_W    (CNT_W),
            .RST_DIV  (DEFAULT_DIV),
            .RST_HIGH (DEFAULT_HIGH)
        ) u_ch (
            .clk_i   (clock_in),
            .rst_i   (reset),
            .en_i    (enable[g]),
            .stage_i (stage[g]),
            .cfg_i   (cfg),
            .busy_o  (busy[g]),
            .clk_o   (clock_out[g]),
            .tick_o  (tick[g])
        );
    end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel, runtime-programmable successor to the fixed clock_divider.
- Derives NUM_CH independent slow outputs from one fast clock_in (50 MHz on board): per-channel period and high time, enable, and an end-of-period tick.
- Divisor/duty changes are staged and applied glitch-free at the period boundary.
- Outputs are registered logic-domain signals, used as slow clocks/strobes or clock enables; no gated or generated clock nets.

Parameters:
- NUM_CH, 2: number of independent divider channels (1..8).
- CNT_W, 32: counter/divisor width.
- DEFAULT_DIV, 50000000: per-channel period in clock_in cycles after reset (1 Hz from 50 MHz).
- DEFAULT_HIGH, 25000000: per-channel high time in cycles after reset.

Ports:
- clock_in, in, 1: sole clock, all logic on rising edge.
- reset, in, 1: synchronous, active-high; overrides all other inputs.
- enable, in, NUM_CH: per-channel run enable.
- load, in, 1: one-cycle request to stage new settings.
- ch_sel, in, CH_W = max(1, clog2(NUM_CH)): channel targeted by load.
- div_in, in, CNT_W: requested period N.
- high_in, in, CNT_W: requested high time H.
- load_ok, out, 1: one-cycle pulse, request accepted.
- load_err, out, 1: one-cycle pulse, request rejected.
- busy, out, NUM_CH: staged settings pending on that channel.
- clock_out, out, NUM_CH: divided output.
- tick, out, NUM_CH: one-cycle pulse at each period end.

Behaviour:
Reset values:
- cnt = 0, div = DEFAULT_DIV, high = DEFAULT_HIGH.
- clock_out, tick, busy, load_ok and load_err all 0.

Per-channel counter (cnt, 0..div-1):
- When enabled, cnt wraps to 0 when cnt == div-1 and increments otherwise.
- clock_out is registered as (cnt < high), evaluated on the pre-increment cnt.
- tick is registered as (cnt == div-1).
- Both outputs therefore lag cnt by one cycle.
- Example, N=4, H=2, enabled from reset release: clock_out = 1,1,0,0 repeating from cycle 1; tick high in cycle 4, 8, ...

Disabled channel:
- cnt is forced to 0; clock_out and tick are 0 from the next cycle.
- Re-enabling restarts the phase exactly as after reset.

Load validation (registered, one-cycle latency):
- Reject when div_in < 2 or ch_sel >= NUM_CH: load_err pulses, no state change.
- Otherwise high is clamped to div_in-1 when high_in >= div_in.
- high = 0 is accepted and gives a constant-low clock_out while tick continues.
- On accept: stage (div, high) into the channel's pending register, set busy, pulse load_ok.

Apply rules:
- Enabled channel: pending settings apply on the cycle cnt wraps to 0. The new period starts at cnt=0; busy clears in the same cycle.
- Disabled channel: pending settings apply on the next cycle.
- A load to an already-busy channel overwrites pending (last wins), busy stays set, load_ok pulses.
- A load arriving in the same cycle as a wrap is staged and applies at the following wrap.

Other boundaries:
- reset asserted mid-period or with load: reset wins; pending is discarded.
- Channels are fully independent; a load to one channel never disturbs another's phase.

Arithmetic:
- Comparisons are unsigned at CNT_W.
- The counter never exceeds div-1, so there is no overflow.

Decomposition:
- Package clkdiv_pkg holds:
  - CNT_W default
  - DEFAULT_DIV and DEFAULT_HIGH
  - MIN_DIV = 2
  - CH_W helper function
  - a struct for {div, high} settings
- Sub-module clkdiv_channel holds the counter, active and pending settings, apply logic, and the clock_out/tick registers.
- The top holds load decode/validation and instantiates NUM_CH channels in a generate loop.

Test Plan:
- Reset release, NUM_CH=2, DEFAULT_DIV=4, DEFAULT_HIGH=2, enable=2'b11 -> both clock_out 1,1,0,0 from cycle 1; tick high in cycles 4 and 8; all outputs 0 during reset.
- load ch0, div_in=5, high_in=2, mid-period -> load_ok next cycle, busy[0] high until wrap; afterwards ch0 period 5 (1,1,0,0,0) with no runt pulse; ch1 phase unchanged.
- load div_in=1, and separately ch_sel=3 with NUM_CH=2 -> load_err pulse, busy unchanged, outputs unaffected.
- load high_in=9, div_in=6 -> high clamped to 5 (1,1,1,1,1,0); load high_in=0 -> clock_out constant 0, tick every 6 cycles.
- Two loads to ch1 before its wrap (div 8, then div 3) -> only div 3 applied; enable[1] dropped mid-period -> clock_out[1] = 0 next cycle; re-enable restarts at phase 0.
- reset asserted with busy[0]=1 and load high -> after reset, defaults active, busy 0, no load_ok/load_err.
